keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 182 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : 4x4 active-low keypad scanner with press/release debouncing.
//            Define KEYPAD_AUTOREPEAT_EN to pulse key_valid repeatedly while held.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_TICKS     = 24000,
  parameter int DEBOUNCE_TICKS = 2400000,
  parameter int REPEAT_TICKS   = 12000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam logic [23:0] C_SCAN_LAST = 24'(SCAN_TICKS - 1);
  localparam logic [23:0] C_DB_LAST   = 24'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    S_SCAN       = 2'd0,
    S_PRESS_DB   = 2'd1,
    S_HELD       = 2'd2,
    S_RELEASE_DB = 2'd3
  } state_t;

  logic [3:0]  r_rows_meta;
  logic [3:0]  r_rows_s;
  state_t      r_state;
  logic [1:0]  r_col_idx;
  logic [1:0]  r_row_idx;
  logic [23:0] r_cnt;
  logic        r_key_valid;
  logic [3:0]  r_key_code;
  logic        r_key_held;

  state_t      w_state_nxt;
  logic [1:0]  w_col_nxt;
  logic [1:0]  w_row_nxt;
  logic [23:0] w_cnt_nxt;
  logic        w_valid_nxt;
  logic [3:0]  w_code_nxt;
  logic        w_held_nxt;
  logic [1:0]  w_first_low;
  logic        w_row_low;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [23:0] C_REP_LAST = 24'(REPEAT_TICKS - 1);
  logic [23:0] r_rep_cnt;
  logic [23:0] w_rep_nxt;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rows_meta <= 4'hF;
      r_rows_s    <= 4'hF;
    end else begin
      r_rows_meta <= rows;
      r_rows_s    <= r_rows_meta;
    end
  end

  // Lowest-index active row wins when several are pressed in one column.
  always_comb begin
    w_first_low = 2'd3;
    if (!r_rows_s[0])      w_first_low = 2'd0;
    else if (!r_rows_s[1]) w_first_low = 2'd1;
    else if (!r_rows_s[2]) w_first_low = 2'd2;
  end

  assign w_row_low = ~r_rows_s[r_row_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_SCAN;
      r_col_idx   <= 2'd0;
      r_row_idx   <= 2'd0;
      r_cnt       <= 24'd0;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'h0;
      r_key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rep_cnt   <= 24'd0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_col_idx   <= w_col_nxt;
      r_row_idx   <= w_row_nxt;
      r_cnt       <= w_cnt_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_code  <= w_code_nxt;
      r_key_held  <= w_held_nxt;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rep_cnt   <= w_rep_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col_idx;
    w_row_nxt   = r_row_idx;
    w_cnt_nxt   = r_cnt + 24'd1;
    w_valid_nxt = 1'b0;
    w_code_nxt  = r_key_code;
    w_held_nxt  = r_key_held;
`ifdef KEYPAD_AUTOREPEAT_EN
    w_rep_nxt   = r_rep_cnt;
`endif
    case (r_state)
      S_SCAN: begin
        if (r_rows_s != 4'hF) begin
          w_row_nxt   = w_first_low;
          w_cnt_nxt   = 24'd0;
          w_state_nxt = S_PRESS_DB;
        end else if (r_cnt == C_SCAN_LAST) begin
          w_cnt_nxt = 24'd0;
          w_col_nxt = r_col_idx + 2'd1;
        end
      end
      S_PRESS_DB: begin
        if (!w_row_low) begin
          w_cnt_nxt   = 24'd0;
          w_col_nxt   = r_col_idx + 2'd1;
          w_state_nxt = S_SCAN;
        end else if (r_cnt == C_DB_LAST) begin
          w_cnt_nxt   = 24'd0;
          w_valid_nxt = 1'b1;
          w_code_nxt  = {r_row_idx, r_col_idx};
          w_held_nxt  = 1'b1;
          w_state_nxt = S_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
          w_rep_nxt   = 24'd0;
`endif
        end
      end
      S_HELD: begin
        w_cnt_nxt = 24'd0;
        if (!w_row_low) begin
          w_state_nxt = S_RELEASE_DB;
`ifdef KEYPAD_AUTOREPEAT_EN
        // Waiting at the last count guarantees a gap between back-to-back pulses.
        end else if (r_rep_cnt == C_REP_LAST) begin
          if (!r_key_valid) begin
            w_valid_nxt = 1'b1;
            w_rep_nxt   = 24'd0;
          end
        end else begin
          w_rep_nxt = r_rep_cnt + 24'd1;
`endif
        end
      end
      S_RELEASE_DB: begin
        if (w_row_low) begin
          w_cnt_nxt   = 24'd0;
          w_state_nxt = S_HELD;
        end else if (r_cnt == C_DB_LAST) begin
          w_cnt_nxt   = 24'd0;
          w_held_nxt  = 1'b0;
          w_col_nxt   = r_col_idx + 2'd1;
          w_state_nxt = S_SCAN;
        end
      end
      default: begin
        w_cnt_nxt   = 24'd0;
        w_state_nxt = S_SCAN;
      end
    endcase
  end

  assign cols      = ~(4'b0001 << r_col_idx);
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign key_held  = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// Directed bench for keypad_scanner with SCAN_TICKS=4, DEBOUNCE_TICKS=10, REPEAT_TICKS=20.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rows = 4'hF;
  logic [3:0] cols;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  int checks = 0;
  int errors = 0;

  keypad_scanner #(
    .SCAN_TICKS    (4),
    .DEBOUNCE_TICKS(10),
    .REPEAT_TICKS  (20)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rows     (rows),
    .cols     (cols),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Wait for cols to newly become v, so the column has just started its dwell.
  task automatic wait_col_edge(input logic [3:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cols != v) break;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cols == v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (key_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_release(input string name);
    bit ok;
    rows = 4'hF;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!key_held) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s release: key_held still %b, required 0", name, key_held);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    rows  = 4'hF;
    repeat (3) @(negedge clk);
    checks += 4;
    if (cols !== 4'b1110) begin errors++; $display("FAIL reset cols: got %b required 1110", cols); end
    if (key_valid !== 1'b0) begin errors++; $display("FAIL reset key_valid: got %b required 0", key_valid); end
    if (key_code !== 4'h0) begin errors++; $display("FAIL reset key_code: got %h required 0", key_code); end
    if (key_held !== 1'b0) begin errors++; $display("FAIL reset key_held: got %b required 0", key_held); end
    reset = 1'b1;
  endtask

  task automatic test_idle_scan;
    logic [3:0] exp;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) @(negedge clk);
      exp = ~(4'b0001 << ((k / 4) % 4));
      checks += 2;
      if (cols !== exp) begin errors++; $display("FAIL idle cols cycle %0d: got %b required %b", k, cols, exp); end
      if (key_valid !== 1'b0) begin errors++; $display("FAIL idle key_valid cycle %0d: got %b required 0", k, key_valid); end
    end
  endtask

  task automatic test_press_hold;
    bit ok;
    bit early;
    bit bad_hold;
    wait_col_edge(4'b1101, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL press wait col1: got %b required 1101", cols); end
    rows  = 4'b1011;
    early = 1'b0;
    // 2 synchronizer cycles + detection cycle + 10 debounce cycles.
    for (int i = 1; i < 13; i++) begin
      @(negedge clk);
      if (key_valid) early = 1'b1;
    end
    @(negedge clk);
    checks += 5;
    if (early) begin errors++; $display("FAIL press early key_valid: got 1 required 0"); end
    if (key_valid !== 1'b1) begin errors++; $display("FAIL press key_valid: got %b required 1", key_valid); end
    if (key_code !== 4'b1001) begin errors++; $display("FAIL press key_code: got %b required 1001", key_code); end
    if (key_held !== 1'b1) begin errors++; $display("FAIL press key_held: got %b required 1", key_held); end
    if (cols !== 4'b1101) begin errors++; $display("FAIL press cols frozen: got %b required 1101", cols); end
    bad_hold = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (key_valid || cols != 4'b1101 || !key_held) bad_hold = 1'b1;
    end
    checks++;
    if (bad_hold) begin errors++; $display("FAIL press hold: got valid=%b cols=%b held=%b required 0/1101/1", key_valid, cols, key_held); end
    rows = 4'hF;
    repeat (12) @(negedge clk);
    checks++;
    if (key_held !== 1'b1) begin errors++; $display("FAIL release held early: got %b required 1", key_held); end
    @(negedge clk);
    checks += 2;
    if (key_held !== 1'b0) begin errors++; $display("FAIL release held: got %b required 0", key_held); end
    if (cols !== 4'b1011) begin errors++; $display("FAIL release next col: got %b required 1011", cols); end
  endtask

  task automatic test_bounce;
    bit ok;
    bit pulse;
    wait_col_edge(4'b1101, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bounce wait col1: got %b required 1101", cols); end
    rows  = 4'b1011;
    pulse = 1'b0;
    repeat (5) begin @(negedge clk); if (key_valid) pulse = 1'b1; end
    rows = 4'hF;
    repeat (2) begin @(negedge clk); if (key_valid) pulse = 1'b1; end
    checks++;
    if (cols !== 4'b1101) begin errors++; $display("FAIL bounce frozen col: got %b required 1101", cols); end
    @(negedge clk);
    checks++;
    if (cols !== 4'b1011) begin errors++; $display("FAIL bounce resume col2: got %b required 1011", cols); end
    repeat (12) begin @(negedge clk); if (key_valid || key_held) pulse = 1'b1; end
    checks++;
    if (pulse) begin errors++; $display("FAIL bounce key_valid: got a pulse required none"); end
  endtask

  task automatic test_release_glitch;
    bit ok;
    bit bad;
    wait_col_edge(4'b1110, ok);
    rows = 4'b1110;
    wait_valid(ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL glitch press: got no key_valid required pulse"); end
    if (key_code !== 4'b0000) begin errors++; $display("FAIL glitch key_code: got %b required 0000", key_code); end
    rows = 4'hF;
    repeat (3) @(negedge clk);
    rows = 4'b1110;
    bad  = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (key_valid || !key_held) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL glitch hold: got valid=%b held=%b required 0/1", key_valid, key_held); end
    wait_release("glitch");
  endtask

  task automatic test_multi_row;
    bit ok;
    bit bad;
    wait_col_edge(4'b1110, ok);
    rows = 4'b0101;
    wait_valid(ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL multi press: got no key_valid required pulse"); end
    if (key_code !== 4'b0100) begin errors++; $display("FAIL multi key_code: got %b required 0100", key_code); end
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      rows = ((i / 5) % 2 == 0) ? 4'b1101 : 4'b0101;
      @(negedge clk);
      if (key_valid || !key_held || cols != 4'b1110) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL multi row3 ignored: got valid=%b held=%b cols=%b required 0/1/1110", key_valid, key_held, cols); end
    wait_release("multi");
  endtask

  task automatic test_reset_mid_press;
    bit ok;
    bit bad;
    wait_col_edge(4'b1110, ok);
    rows = 4'b1110;
    bad  = 1'b0;
    repeat (6) begin @(negedge clk); if (key_valid) bad = 1'b1; end
    reset = 1'b0;
    #1;
    checks += 5;
    if (bad) begin errors++; $display("FAIL midreset early key_valid: got 1 required 0"); end
    if (cols !== 4'b1110) begin errors++; $display("FAIL midreset cols: got %b required 1110", cols); end
    if (key_valid !== 1'b0) begin errors++; $display("FAIL midreset key_valid: got %b required 0", key_valid); end
    if (key_code !== 4'h0) begin errors++; $display("FAIL midreset key_code: got %h required 0", key_code); end
    if (key_held !== 1'b0) begin errors++; $display("FAIL midreset key_held: got %b required 0", key_held); end
    rows = 4'hF;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bad   = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(negedge clk);
      if (key_valid || cols != ~(4'b0001 << ((k / 4) % 4))) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL midreset rescan: got cols=%b valid=%b required scan from col0, no pulse", cols, key_valid); end
  endtask

  task automatic test_repeat;
    bit ok;
    bit exp;
    int bad_at;
    wait_col_edge(4'b1110, ok);
    rows = 4'b1110;
    wait_valid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL repeat press: got no key_valid required pulse"); end
    bad_at = -1;
    for (int i = 1; i <= 61; i++) begin
      @(negedge clk);
`ifdef KEYPAD_AUTOREPEAT_EN
      exp = (i % 20 == 0);
`else
      exp = 1'b0;
`endif
      if (key_valid !== exp && bad_at < 0) bad_at = i;
    end
    checks++;
    if (bad_at >= 0) begin errors++; $display("FAIL repeat pulses: got wrong key_valid at +%0d, required pulses only per repeat setting", bad_at); end
    checks++;
    if (key_code !== 4'b0000) begin errors++; $display("FAIL repeat key_code: got %b required 0000", key_code); end
    wait_release("repeat");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_scan();
    test_press_hold();
    test_bounce();
    test_release_glitch();
    test_multi_row();
    test_reset_mid_press();
    test_repeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
